// File: rtl/ysyx_22050550_wbu_arbiter.sv
// Writeback arbiter: three one-entry holding buffers (EXU, LSU, MDU) share one registered writeback port.
// Define YSYX_22050550_WB_RR_EN for round-robin grant; otherwise fixed priority LSU > MDU > EXU.
module ysyx_22050550_wbu_arbiter #(
    parameter int DATA_W = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_EXU_valid,
    output logic              io_EXU_ready,
    input  logic [4:0]        io_EXU_waddr,
    input  logic              io_EXU_wen,
    input  logic [DATA_W-1:0] io_EXU_wdata,
    input  logic              io_LSU_valid,
    output logic              io_LSU_ready,
    input  logic [4:0]        io_LSU_waddr,
    input  logic              io_LSU_wen,
    input  logic [DATA_W-1:0] io_LSU_wdata,
    input  logic              io_MDU_valid,
    output logic              io_MDU_ready,
    input  logic [4:0]        io_MDU_waddr,
    input  logic              io_MDU_wen,
    input  logic [DATA_W-1:0] io_MDU_wdata,
    output logic              io_WB_valid,
    output logic [4:0]        io_WB_waddr,
    output logic              io_WB_wen,
    output logic [DATA_W-1:0] io_WB_wdata
);

    logic [2:0]        w_valid;
    logic [2:0]        w_wen;
    logic [4:0]        w_waddr [3];
    logic [DATA_W-1:0] w_wdata [3];
    logic [2:0]        w_ready;
    logic [2:0]        w_fire;
    logic [2:0]        w_grant;
    logic              w_anyGrant;
    logic [1:0]        w_gntIdx;
    logic [1:0]        w_candIdx;
    logic [1:0]        w_base;

    logic [2:0]        r_full;
    logic [2:0]        r_wen;
    logic [4:0]        r_waddr [3];
    logic [DATA_W-1:0] r_wdata [3];

    logic              r_wbValid;
    logic [4:0]        r_wbWaddr;
    logic              r_wbWen;
    logic [DATA_W-1:0] r_wbWdata;

    // Port index order 0 = EXU, 1 = LSU, 2 = MDU; arbitration walks this ring from w_base.
    function automatic logic [1:0] rotIdx(input logic [1:0] base, input int k);
        logic [2:0] s;
        s = {1'b0, base} + 3'(k);
        if (s >= 3'd3) s = s - 3'd3;
        return s[1:0];
    endfunction

    assign w_valid    = {io_MDU_valid, io_LSU_valid, io_EXU_valid};
    assign w_wen      = {io_MDU_wen, io_LSU_wen, io_EXU_wen};
    assign w_waddr[0] = io_EXU_waddr;
    assign w_waddr[1] = io_LSU_waddr;
    assign w_waddr[2] = io_MDU_waddr;
    assign w_wdata[0] = io_EXU_wdata;
    assign w_wdata[1] = io_LSU_wdata;
    assign w_wdata[2] = io_MDU_wdata;

    assign w_ready = ~r_full | w_grant;
    assign w_fire  = w_valid & w_ready;

    assign io_EXU_ready = w_ready[0];
    assign io_LSU_ready = w_ready[1];
    assign io_MDU_ready = w_ready[2];

`ifdef YSYX_22050550_WB_RR_EN
    logic [1:0] r_ptr;

    // Pointer names the highest-priority port; it moves past the winner only when a grant happens.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ptr <= 2'd0;
        end else if (w_anyGrant) begin
            r_ptr <= rotIdx(w_gntIdx, 1);
        end
    end

    assign w_base = r_ptr;
`else
    assign w_base = 2'd1;
`endif

    always_comb begin
        w_grant    = '0;
        w_anyGrant = 1'b0;
        w_gntIdx   = 2'd0;
        w_candIdx  = 2'd0;
        for (int k = 0; k < 3; k++) begin
            w_candIdx = rotIdx(w_base, k);
            if (!w_anyGrant && r_full[w_candIdx]) begin
                w_anyGrant = 1'b1;
                w_gntIdx   = w_candIdx;
            end
        end
        if (w_anyGrant) w_grant[w_gntIdx] = 1'b1;
    end

    // A fire on a granted buffer overwrites it in place, so drain and refill share one cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_full <= '0;
            r_wen  <= '0;
            for (int i = 0; i < 3; i++) begin
                r_waddr[i] <= '0;
                r_wdata[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (w_fire[i]) begin
                    r_full[i]  <= 1'b1;
                    r_waddr[i] <= w_waddr[i];
                    r_wen[i]   <= w_wen[i] & (w_waddr[i] != 5'd0);
                    r_wdata[i] <= w_wdata[i];
                end else if (w_grant[i]) begin
                    r_full[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wbValid <= 1'b0;
            r_wbWaddr <= '0;
            r_wbWen   <= 1'b0;
            r_wbWdata <= '0;
        end else if (w_anyGrant) begin
            r_wbValid <= 1'b1;
            r_wbWaddr <= r_waddr[w_gntIdx];
            r_wbWen   <= r_wen[w_gntIdx];
            r_wbWdata <= r_wdata[w_gntIdx];
        end else begin
            r_wbValid <= 1'b0;
            r_wbWen   <= 1'b0;
        end
    end

    assign io_WB_valid = r_wbValid;
    assign io_WB_waddr = r_wbWaddr;
    assign io_WB_wen   = r_wbWen;
    assign io_WB_wdata = r_wbWdata;

endmodule

// File: tb/tb_ysyx_22050550_wbu_arbiter.sv
// Directed self-checking bench for ysyx_22050550_wbu_arbiter; expectations follow the build's
// YSYX_22050550_WB_RR_EN setting.
module tb_ysyx_22050550_wbu_arbiter;

    logic        clock;
    logic        reset;
    logic        exuValid, lsuValid, mduValid;
    logic        exuReady, lsuReady, mduReady;
    logic [4:0]  exuWaddr, lsuWaddr, mduWaddr;
    logic        exuWen, lsuWen, mduWen;
    logic [63:0] exuWdata, lsuWdata, mduWdata;
    logic        wbValid;
    logic [4:0]  wbWaddr;
    logic        wbWen;
    logic [63:0] wbWdata;

    int errCount = 0;
    int checkCount = 0;

    ysyx_22050550_wbu_arbiter #(.DATA_W(64)) dut (
        .clock        (clock),
        .reset        (reset),
        .io_EXU_valid (exuValid),
        .io_EXU_ready (exuReady),
        .io_EXU_waddr (exuWaddr),
        .io_EXU_wen   (exuWen),
        .io_EXU_wdata (exuWdata),
        .io_LSU_valid (lsuValid),
        .io_LSU_ready (lsuReady),
        .io_LSU_waddr (lsuWaddr),
        .io_LSU_wen   (lsuWen),
        .io_LSU_wdata (lsuWdata),
        .io_MDU_valid (mduValid),
        .io_MDU_ready (mduReady),
        .io_MDU_waddr (mduWaddr),
        .io_MDU_wen   (mduWen),
        .io_MDU_wdata (mduWdata),
        .io_WB_valid  (wbValid),
        .io_WB_waddr  (wbWaddr),
        .io_WB_wen    (wbWen),
        .io_WB_wdata  (wbWdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Drive one producer port: 0 = EXU, 1 = LSU, 2 = MDU.
    task automatic applyStimulus(input int port, input logic valid, input logic [4:0] waddr,
                                 input logic wen, input logic [63:0] wdata);
        case (port)
            0: begin exuValid = valid; exuWaddr = waddr; exuWen = wen; exuWdata = wdata; end
            1: begin lsuValid = valid; lsuWaddr = waddr; lsuWen = wen; lsuWdata = wdata; end
            default: begin mduValid = valid; mduWaddr = waddr; mduWen = wen; mduWdata = wdata; end
        endcase
    endtask

    task automatic clearAll();
        applyStimulus(0, 1'b0, 5'd0, 1'b0, 64'd0);
        applyStimulus(1, 1'b0, 5'd0, 1'b0, 64'd0);
        applyStimulus(2, 1'b0, 5'd0, 1'b0, 64'd0);
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulseReset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin : mainSeq
        logic found;
        clearAll();
        reset = 1'b1;
        tick();
        tick();

        // Reset state of every output.
        checkOutput("rst_valid", 64'(wbValid), 64'd0);
        checkOutput("rst_wen", 64'(wbWen), 64'd0);
        checkOutput("rst_waddr", 64'(wbWaddr), 64'd0);
        checkOutput("rst_wdata", wbWdata, 64'd0);
        checkOutput("rst_ready", 64'({mduReady, lsuReady, exuReady}), 64'b111);
        reset = 1'b0;

        // Load captured, then reset lands before it can be written back.
        applyStimulus(1, 1'b1, 5'd5, 1'b1, 64'hAB);
        tick();
        clearAll();
        checkOutput("rload_full_ready", 64'(lsuReady), 64'd1);
        reset = 1'b1;
        #1;
        checkOutput("rload_ready", 64'(lsuReady), 64'd1);
        tick();
        checkOutput("rload_valid", 64'(wbValid), 64'd0);
        reset = 1'b0;
        tick();
        checkOutput("rload_valid2", 64'(wbValid), 64'd0);

        // Single EXU result: beat appears one cycle after capture, then waddr/wdata hold.
        applyStimulus(0, 1'b1, 5'd3, 1'b1, 64'h1234);
        tick();
        clearAll();
        checkOutput("exu_early", 64'(wbValid), 64'd0);
        tick();
        checkOutput("exu_valid", 64'(wbValid), 64'd1);
        checkOutput("exu_waddr", 64'(wbWaddr), 64'd3);
        checkOutput("exu_wen", 64'(wbWen), 64'd1);
        checkOutput("exu_wdata", wbWdata, 64'h1234);
        tick();
        checkOutput("exu_after", 64'(wbValid), 64'd0);
        checkOutput("exu_hold_addr", 64'(wbWaddr), 64'd3);
        checkOutput("exu_hold_data", wbWdata, 64'h1234);

        // x0 destination suppresses wen; a store beat still retires with wen low.
        applyStimulus(0, 1'b1, 5'd0, 1'b1, 64'h55);
        tick();
        clearAll();
        tick();
        checkOutput("x0_valid", 64'(wbValid), 64'd1);
        checkOutput("x0_wen", 64'(wbWen), 64'd0);
        applyStimulus(1, 1'b1, 5'd7, 1'b0, 64'h77);
        tick();
        clearAll();
        tick();
        checkOutput("st_valid", 64'(wbValid), 64'd1);
        checkOutput("st_wen", 64'(wbWen), 64'd0);
        checkOutput("st_waddr", 64'(wbWaddr), 64'd7);

        // Three-way collision from a fresh reset.
        pulseReset();
        applyStimulus(0, 1'b1, 5'd1, 1'b1, 64'h101);
        applyStimulus(1, 1'b1, 5'd2, 1'b1, 64'h202);
        applyStimulus(2, 1'b1, 5'd3, 1'b1, 64'h303);
        tick();
        clearAll();
`ifdef YSYX_22050550_WB_RR_EN
        checkOutput("col_ready", 64'({mduReady, lsuReady, exuReady}), 64'b001);
        tick();
        checkOutput("col_b1", 64'({wbValid, wbWaddr}), 64'({1'b1, 5'd1}));
        checkOutput("col_d1", wbWdata, 64'h101);
        tick();
        checkOutput("col_b2", 64'({wbValid, wbWaddr}), 64'({1'b1, 5'd2}));
        tick();
        checkOutput("col_b3", 64'({wbValid, wbWaddr}), 64'({1'b1, 5'd3}));
`else
        checkOutput("col_ready", 64'({mduReady, lsuReady, exuReady}), 64'b010);
        tick();
        checkOutput("col_b1", 64'({wbValid, wbWaddr}), 64'({1'b1, 5'd2}));
        checkOutput("col_d1", wbWdata, 64'h202);
        tick();
        checkOutput("col_b2", 64'({wbValid, wbWaddr}), 64'({1'b1, 5'd3}));
        tick();
        checkOutput("col_b3", 64'({wbValid, wbWaddr}), 64'({1'b1, 5'd1}));
`endif
        tick();
        checkOutput("col_end", 64'(wbValid), 64'd0);
        checkOutput("col_ready_end", 64'({mduReady, lsuReady, exuReady}), 64'b111);

        // EXU streams eight results back to back with no bubble.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 1'b1, 5'(8 + i), 1'b1, 64'(i * 16 + 1));
            checkOutput($sformatf("str_ready%0d", i), 64'(exuReady), 64'd1);
            tick();
            if (i > 0) begin
                checkOutput($sformatf("str_beat%0d", i - 1), 64'({wbValid, wbWaddr}), 64'({1'b1, 5'(8 + i - 1)}));
            end
        end
        clearAll();
        tick();
        checkOutput("str_beat7", 64'({wbValid, wbWaddr}), 64'({1'b1, 5'd15}));
        checkOutput("str_data7", wbWdata, 64'(7 * 16 + 1));
        tick();
        checkOutput("str_end", 64'(wbValid), 64'd0);

`ifdef YSYX_22050550_WB_RR_EN
        // LSU and MDU stay saturated; a single EXU result must still retire within three grants.
        applyStimulus(1, 1'b1, 5'd20, 1'b1, 64'h20);
        applyStimulus(2, 1'b1, 5'd21, 1'b1, 64'h21);
        tick();
        tick();
        tick();
        applyStimulus(0, 1'b1, 5'd22, 1'b1, 64'h22);
        checkOutput("fair_exu_ready", 64'(exuReady), 64'd1);
        tick();
        applyStimulus(0, 1'b0, 5'd0, 1'b0, 64'd0);
        found = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (wbValid && wbWaddr == 5'd22) found = 1'b1;
        end
        checkOutput("fair_exu_beat", 64'(found), 64'd1);
        clearAll();
        pulseReset();
`endif

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

    // Hard timeout so the run always reaches a verdict.
    initial begin : watchdog
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        errCount++;
        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $fatal(1, "[TB] timeout");
    end

endmodule
